// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - state encoding and parameter defaults for the vend initiator
package vend_pkg;

  localparam int PRICE_COINS_DEF  = 2;
  localparam int COIN_GAP_DEF     = 4;
  localparam int RESP_TIMEOUT_DEF = 16;
  localparam int CNT_W_DEF        = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COIN,
    S_GAP,
    S_WAIT_COLA,
    S_REQ_REFUND,
    S_WAIT_REFUND
  } state_t;

endpackage

// File: rtl/vend_timer.sv
// rtl/vend_timer.sv - loadable 8-bit down-counter, expired while the count sits at zero
module vend_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign expired = (cnt == 8'd0);

endmodule

// File: rtl/vend_initiator.sv
// rtl/vend_initiator.sv - drives coin/refund handshakes into a vending FSM; VEND_STATS_EN builds the purchase/refund counters
module vend_initiator
  import vend_pkg::*;
#(
  parameter int PRICE_COINS  = PRICE_COINS_DEF,
  parameter int COIN_GAP     = COIN_GAP_DEF,
  parameter int RESP_TIMEOUT = RESP_TIMEOUT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             buy_req,
  input  logic             cancel_req,
  input  logic             cola,
  input  logic             refund,
  output logic             coin,
  output logic             refund_request,
  output logic             busy,
  output logic             done_cola,
  output logic             done_refund,
  output logic             timeout_err,
  output logic [CNT_W-1:0] vend_count,
  output logic [CNT_W-1:0] refund_count
);

  state_t     state, state_n;
  logic [3:0] coin_cnt, coin_cnt_n;
  logic       cancel_pend, cancel_pend_n;
  logic       tmr_load, tmr_expired;
  logic [7:0] tmr_val;
  logic       done_cola_n, done_refund_n, timeout_n;

  vend_timer u_timer (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_n       = state;
    coin_cnt_n    = coin_cnt;
    cancel_pend_n = cancel_pend;
    tmr_load      = 1'b0;
    tmr_val       = 8'd0;
    done_cola_n   = 1'b0;
    done_refund_n = 1'b0;
    timeout_n     = 1'b0;
    case (state)
      S_IDLE: begin
        if (buy_req) begin
          state_n    = S_COIN;
          coin_cnt_n = 4'd0;
        end
      end
      S_COIN: begin
        coin_cnt_n = coin_cnt + 4'd1;
        if (cancel_req) cancel_pend_n = 1'b1;
        // a cancel landing on the final coin is dropped: the price is already paid
        if (coin_cnt_n == 4'(PRICE_COINS)) begin
          state_n  = S_WAIT_COLA;
          tmr_load = 1'b1;
          tmr_val  = 8'(RESP_TIMEOUT - 1);
        end else begin
          state_n  = S_GAP;
          tmr_load = 1'b1;
          tmr_val  = 8'(COIN_GAP - 1);
        end
      end
      S_GAP: begin
        if (cancel_req || cancel_pend) begin
          cancel_pend_n = 1'b1;
          state_n       = S_REQ_REFUND;
        end else if (tmr_expired) begin
          state_n = S_COIN;
        end
      end
      S_WAIT_COLA: begin
        if (cola) begin
          done_cola_n = 1'b1;
          state_n     = S_IDLE;
        end else if (tmr_expired) begin
          timeout_n = 1'b1;
          state_n   = S_IDLE;
        end
      end
      S_REQ_REFUND: begin
        state_n  = S_WAIT_REFUND;
        tmr_load = 1'b1;
        tmr_val  = 8'(RESP_TIMEOUT - 1);
      end
      S_WAIT_REFUND: begin
        if (refund) begin
          done_refund_n = 1'b1;
          state_n       = S_IDLE;
        end else if (tmr_expired) begin
          timeout_n = 1'b1;
          state_n   = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (state_n == S_IDLE) cancel_pend_n = 1'b0;
  end

  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state          <= S_IDLE;
      coin_cnt       <= 4'd0;
      cancel_pend    <= 1'b0;
      coin           <= 1'b0;
      refund_request <= 1'b0;
      busy           <= 1'b0;
      done_cola      <= 1'b0;
      done_refund    <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      state          <= state_n;
      coin_cnt       <= coin_cnt_n;
      cancel_pend    <= cancel_pend_n;
      coin           <= (state_n == S_COIN);
      refund_request <= (state_n == S_REQ_REFUND);
      busy           <= (state_n != S_IDLE);
      done_cola      <= done_cola_n;
      done_refund    <= done_refund_n;
      timeout_err    <= timeout_n;
    end
  end

`ifdef VEND_STATS_EN
  logic [CNT_W-1:0] vend_cnt_q, refund_cnt_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vend_cnt_q   <= '0;
      refund_cnt_q <= '0;
    end else begin
      if (done_cola_n)   vend_cnt_q   <= vend_cnt_q + 1'b1;
      if (done_refund_n) refund_cnt_q <= refund_cnt_q + 1'b1;
    end
  end

  assign vend_count   = vend_cnt_q;
  assign refund_count = refund_cnt_q;
`else
  assign vend_count   = '0;
  assign refund_count = '0;
`endif

endmodule

// File: tb/tb_vend_initiator.sv
// tb/tb_vend_initiator.sv - scoreboard bench for vend_initiator; expected counters follow VEND_STATS_EN
module tb_vend_initiator;

`ifdef VEND_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  localparam int K_COIN = 0, K_RREQ = 1, K_DCOLA = 2, K_DREF = 3, K_TMO = 4;

  typedef struct {
    int kind;
    int cyc;
    int v;
    int r;
  } evt_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       buy_req = 1'b0, cancel_req = 1'b0, cola = 1'b0, refund = 1'b0;
  logic       coin, refund_request, busy, done_cola, done_refund, timeout_err;
  logic [7:0] vend_count, refund_count;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   vm = 0;
  int   rm = 0;
  evt_t exp_q[$];

  vend_initiator dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .buy_req        (buy_req),
    .cancel_req     (cancel_req),
    .cola           (cola),
    .refund         (refund),
    .coin           (coin),
    .refund_request (refund_request),
    .busy           (busy),
    .done_cola      (done_cola),
    .done_refund    (done_refund),
    .timeout_err    (timeout_err),
    .vend_count     (vend_count),
    .refund_count   (refund_count)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic int bump(input int x);
    return (STATS != 0) ? ((x + 1) % 256) : 0;
  endfunction

  task automatic push(input int k, input int c);
    evt_t e;
    e.kind = k;
    e.cyc  = c;
    e.v    = vm;
    e.r    = rm;
    exp_q.push_back(e);
  endtask

  task automatic check(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, expv);
    end
  endtask

  task automatic see(input int k);
    evt_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL evt_unexpected cyc=%0d actual_kind=%0d required=none", cyc, k);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.v != int'(vend_count) || e.r != int'(refund_count)) begin
        bad++;
        $display("FAIL evt actual kind=%0d cyc=%0d vc=%0d rc=%0d required kind=%0d cyc=%0d vc=%0d rc=%0d",
                 k, cyc, vend_count, refund_count, e.kind, e.cyc, e.v, e.r);
      end
    end
  endtask

  always @(negedge sys_clk) begin
    if (coin)           see(K_COIN);
    if (refund_request) see(K_RREQ);
    if (done_cola)      see(K_DCOLA);
    if (done_refund)    see(K_DREF);
    if (timeout_err)    see(K_TMO);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic pulse_buy();
    buy_req = 1'b1;
    step(1);
    buy_req = 1'b0;
  endtask

  initial begin
    int t0;
    step(3);
    sys_rst = 1'b0;
    check("rst_coin", int'(coin), 0);
    check("rst_rreq", int'(refund_request), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done_cola | done_refund), 0);
    check("rst_tmo", int'(timeout_err), 0);
    check("rst_vcnt", int'(vend_count), 0);
    check("rst_rcnt", int'(refund_count), 0);

    // purchase: coins one and six cycles after buy, cola nine cycles after
    t0 = cyc;
    push(K_COIN, t0 + 1);
    push(K_COIN, t0 + 6);
    vm = bump(vm);
    push(K_DCOLA, t0 + 10);
    pulse_buy();
    check("buy_busy", int'(busy), 1);
    wait_until(t0 + 9);
    cola = 1'b1;
    step(1);
    cola = 1'b0;
    check("cola_idle", int'(busy), 0);
    check("cola_vcnt", int'(vend_count), vm);
    step(2);

    // cancel in second gap cycle; cola alongside refund in WAIT_REFUND
    t0 = cyc;
    push(K_COIN, t0 + 1);
    push(K_RREQ, t0 + 4);
    rm = bump(rm);
    push(K_DREF, t0 + 8);
    pulse_buy();
    wait_until(t0 + 3);
    cancel_req = 1'b1;
    step(1);
    cancel_req = 1'b0;
    wait_until(t0 + 7);
    refund = 1'b1;
    cola   = 1'b1;
    step(1);
    refund = 1'b0;
    cola   = 1'b0;
    check("ref_rcnt", int'(refund_count), rm);
    step(2);

    // no cola: timeout 16 cycles into WAIT_COLA; stray refund ignored
    t0 = cyc;
    push(K_COIN, t0 + 1);
    push(K_COIN, t0 + 6);
    push(K_TMO, t0 + 23);
    pulse_buy();
    wait_until(t0 + 10);
    refund = 1'b1;
    step(1);
    refund = 1'b0;
    wait_until(t0 + 22);
    check("tmo_busy_before", int'(busy), 1);
    wait_until(t0 + 24);
    check("tmo_busy_after", int'(busy), 0);
    step(1);

    // cancel in IDLE, then buy and stray cola during GAP
    cancel_req = 1'b1;
    step(1);
    cancel_req = 1'b0;
    check("idle_cancel_busy", int'(busy), 0);
    t0 = cyc;
    push(K_COIN, t0 + 1);
    push(K_COIN, t0 + 6);
    vm = bump(vm);
    push(K_DCOLA, t0 + 10);
    pulse_buy();
    wait_until(t0 + 3);
    buy_req = 1'b1;
    cola    = 1'b1;
    step(1);
    buy_req = 1'b0;
    cola    = 1'b0;
    wait_until(t0 + 9);
    cola = 1'b1;
    step(1);
    cola = 1'b0;
    step(2);

    // cancel during the final coin is dropped
    t0 = cyc;
    push(K_COIN, t0 + 1);
    push(K_COIN, t0 + 6);
    vm = bump(vm);
    push(K_DCOLA, t0 + 9);
    pulse_buy();
    wait_until(t0 + 6);
    cancel_req = 1'b1;
    step(1);
    cancel_req = 1'b0;
    wait_until(t0 + 8);
    cola = 1'b1;
    step(1);
    cola = 1'b0;
    step(2);

    // reset in GAP with a simultaneous buy, then a fresh purchase
    t0 = cyc;
    push(K_COIN, t0 + 1);
    pulse_buy();
    wait_until(t0 + 3);
    sys_rst = 1'b1;
    buy_req = 1'b1;
    step(1);
    sys_rst = 1'b0;
    buy_req = 1'b0;
    vm = 0;
    rm = 0;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_coin", int'(coin), 0);
    check("mid_rst_vcnt", int'(vend_count), 0);
    check("mid_rst_rcnt", int'(refund_count), 0);
    step(1);
    check("mid_rst_stay_idle", int'(busy), 0);
    t0 = cyc;
    push(K_COIN, t0 + 1);
    push(K_COIN, t0 + 6);
    vm = bump(vm);
    push(K_DCOLA, t0 + 10);
    pulse_buy();
    wait_until(t0 + 9);
    cola = 1'b1;
    step(1);
    cola = 1'b0;
    check("post_rst_vcnt", int'(vend_count), vm);
    step(4);

    check("events_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
